// File: rtl/flash_word_reader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_word_reader_if                                                  |
// | CPU word-read bus plus byte-wide SPI flash controller handshake.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface flash_word_reader_if;
    logic        bus_req;
    logic [23:0] bus_addr;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_err;
    logic [23:0] flash_addr;
    logic        flash_rd;
    logic        flash_busy;
    logic [7:0]  flash_data;

    modport slave (
        input  bus_req, bus_addr, flash_busy, flash_data,
        output bus_rdata, bus_ready, bus_err, flash_addr, flash_rd
    );

    modport master (
        output bus_req, bus_addr, flash_busy, flash_data,
        input  bus_rdata, bus_ready, bus_err, flash_addr, flash_rd
    );
endinterface
`default_nettype wire

// File: rtl/flash_word_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_word_reader                                                     |
// | Word reads assembled little-endian from four single-byte flash reads. |
// | Optional one-entry word cache: FLASH_WORD_CACHE_EN.                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module flash_word_reader #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    flash_word_reader_if.slave  bif
);
    localparam int              c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [23:0]         r_wbase;
    logic [1:0]          r_k;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [23:0]         r_lanes;
    logic [31:0]         r_rdata;
    logic                r_ready;
    logic                r_err;
    logic [23:0]         r_flash_addr;
    logic                r_flash_rd;

    logic [23:0]         w_req_wbase;
    logic [23:0]         w_issue_addr;
    logic                w_accept;
    logic                w_take_hit;
    logic                w_issue;
    logic                w_capture;
    logic                w_done_ok;
    logic                w_timeout;
    logic                w_tmo;
    logic                w_hit;
    logic [31:0]         w_hit_data;

    assign w_req_wbase = (bif.bus_addr & 24'hFFFFFC) + BASE_ADDR;
    assign w_tmo       = (r_cnt == c_TMO_LAST);

`ifdef FLASH_WORD_CACHE_EN
    logic        r_cache_vld;
    logic [21:0] r_cache_tag;
    logic [31:0] r_cache_data;

    assign w_hit      = r_cache_vld && (r_cache_tag == w_req_wbase[23:2]);
    assign w_hit_data = r_cache_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_vld  <= 1'b0;
            r_cache_tag  <= '0;
            r_cache_data <= '0;
        end else if (w_done_ok) begin
            r_cache_vld  <= 1'b1;
            r_cache_tag  <= r_wbase[23:2];
            r_cache_data <= {bif.flash_data, r_lanes};
        end else if (w_timeout) begin
            r_cache_vld  <= 1'b0;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'h0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_take_hit   = 1'b0;
        w_issue      = 1'b0;
        w_issue_addr = r_flash_addr;
        w_capture    = 1'b0;
        w_done_ok    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bif.bus_req) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_take_hit  = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_addr = w_req_wbase;
                        w_state_nxt  = ISSUE;
                    end
                end
            end
            ISSUE: w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bif.flash_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (w_tmo) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            WAIT_DONE: begin
                // A completed byte wins over a timeout landing in the same cycle.
                if (!bif.flash_busy) begin
                    w_capture = 1'b1;
                    if (r_k == 2'd3) begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_issue      = 1'b1;
                        w_issue_addr = r_wbase + {22'd0, r_k + 2'd1};
                        w_state_nxt  = ISSUE;
                    end
                end else if (w_tmo) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbase      <= '0;
            r_k          <= '0;
            r_cnt        <= '0;
            r_lanes      <= '0;
            r_rdata      <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_flash_addr <= '0;
            r_flash_rd   <= 1'b0;
        end else begin
            r_flash_rd <= w_issue;
            r_ready    <= w_done_ok | w_timeout | w_take_hit;
            r_err      <= w_timeout;
            if (w_issue) r_flash_addr <= w_issue_addr;
            if (w_accept) begin
                r_wbase <= w_req_wbase;
                r_k     <= 2'd0;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                case (r_k)
                    2'd0:    r_lanes[7:0]   <= bif.flash_data;
                    2'd1:    r_lanes[15:8]  <= bif.flash_data;
                    2'd2:    r_lanes[23:16] <= bif.flash_data;
                    default: ;
                endcase
                r_k <= r_k + 2'd1;
            end
            // Byte 3 goes straight into the response word on the capture edge.
            if (w_done_ok)       r_rdata <= {bif.flash_data, r_lanes};
            else if (w_timeout)  r_rdata <= 32'hFFFF_FFFF;
            else if (w_take_hit) r_rdata <= w_hit_data;
        end
    end

    assign bif.bus_rdata  = r_rdata;
    assign bif.bus_ready  = r_ready;
    assign bif.bus_err    = r_err;
    assign bif.flash_addr = r_flash_addr;
    assign bif.flash_rd   = r_flash_rd;
endmodule
`default_nettype wire

// File: tb/tb_flash_word_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_flash_word_reader                                                  |
// | Scoreboarded random/directed bench with a behavioural flash model.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_flash_word_reader;
    localparam logic [23:0] BASE = 24'h000010;
    localparam int          TMO  = 16;

    logic clk = 1'b0;
    logic rst_n;

    flash_word_reader_if bif();

    flash_word_reader #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [32:0] exp_q[$];
    logic [23:0] addr_q[$];
    int          rd_count    = 0;
    bit          stuck       = 1'b0;
    bit          m_vld       = 1'b0;
    logic [21:0] m_tag       = '0;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rdata", bif.bus_rdata, 0);
        check("rst_ready", bif.bus_ready, 0);
        check("rst_err", bif.bus_err, 0);
        check("rst_flash_addr", bif.flash_addr, 0);
        check("rst_flash_rd", bif.flash_rd, 0);
    endtask

    // Byte-wide controller: busy rises 1..3 cycles after the trigger, data valid when busy drops.
    initial begin : flash_model
        logic [23:0] a;
        bit          ok;
        int          rise;
        int          hold;
        bif.flash_busy = 1'b0;
        bif.flash_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                bif.flash_busy = 1'b0;
                continue;
            end
            if (bif.flash_rd === 1'b1) begin
                a = bif.flash_addr;
                rd_count++;
                check("flash_rd_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("flash_addr", a, addr_q.pop_front());
                if (!stuck) begin
                    rise = $urandom_range(0, 2);
                    hold = $urandom_range(1, 4);
                    wait_edges(1 + rise, ok);
                    if (ok) begin
                        #1;
                        bif.flash_busy = 1'b1;
                        bif.flash_data = 8'($urandom);
                        wait_edges(hold, ok);
                    end
                    if (ok) begin
                        #1;
                        check("flash_addr_hold", bif.flash_addr, a);
                        bif.flash_busy = 1'b0;
                        bif.flash_data = flash_byte(a);
                    end else begin
                        bif.flash_busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("err_only_with_ready", bif.bus_err & ~bif.bus_ready, 0);
                if (bif.bus_ready === 1'b1) begin
                    check("ready_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("rdata", bif.bus_rdata, e[31:0]);
                        check("err", bif.bus_err, e[32]);
                    end
                end
            end
        end
    end

    // Issue one request (starts just after a rising edge); stick = flash never answers.
    task automatic do_read(input logic [23:0] a, input bit keep, input bit stick);
        logic [23:0] wb;
        logic [31:0] w;
        bit          hit;
        bit          seen;
        int          rd0;
        int          n;
        int          exp_rd;
        wb  = (a & 24'hFFFFFC) + BASE;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = flash_byte(wb + 24'(i));
        hit = 1'b0;
`ifdef FLASH_WORD_CACHE_EN
        hit = m_vld && (m_tag == wb[23:2]);
`endif
        if (hit) begin
            exp_rd = 0;
            exp_q.push_back({1'b0, w});
        end else if (stick) begin
            exp_rd = 1;
            addr_q.push_back(wb);
            exp_q.push_back({1'b1, 32'hFFFF_FFFF});
            m_vld = 1'b0;
        end else begin
            exp_rd = 4;
            for (int i = 0; i < 4; i++) addr_q.push_back(wb + 24'(i));
            exp_q.push_back({1'b0, w});
            m_vld = 1'b1;
            m_tag = wb[23:2];
        end
        stuck        = stick;
        rd0          = rd_count;
        bif.bus_addr = a;
        bif.bus_req  = 1'b1;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bif.bus_ready === 1'b1) seen = 1'b1;
        end
        check("ready_seen", seen, 1);
        if (hit) check("hit_latency", n, 2);
        check("flash_rd_count", rd_count - rd0, exp_rd);
        @(posedge clk);
        #1;
        stuck = 1'b0;
        if (!keep) bif.bus_req = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [23:0] prev;
        logic [23:0] a;
        bit          keep;
        bit          stick;
        int          rd0;
        int          n;
        bif.bus_req  = 1'b0;
        bif.bus_addr = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_read(24'h0000F3, 1'b0, 1'b0);   // flash 0x100..0x103 -> 5958_5B5A
        do_read(24'hFFFFF0, 1'b0, 1'b0);   // wraps to flash 0x000000..0x000003
        do_read(24'h000123, 1'b0, 1'b1);   // timeout with busy stuck low
        do_read(24'h000123, 1'b0, 1'b0);

        // Reset during byte 2 of a read.
        rd0 = rd_count;
        for (int i = 0; i < 4; i++) addr_q.push_back(24'h000090 + 24'(i));
        bif.bus_addr = 24'h000080;
        bif.bus_req  = 1'b1;
        n = 0;
        while (rd_count < rd0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_byte2", rd_count - rd0, 2);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        bif.bus_req = 1'b0;
        exp_q.delete();
        addr_q.delete();
        m_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        do_read(24'h000200, 1'b0, 1'b0);

        // Back-to-back with bus_req held across both.
        do_read(24'h000000, 1'b1, 1'b0);
        do_read(24'h000004, 1'b0, 1'b0);

        // Cache pattern (plain re-reads when the cache is not built in).
        do_read(24'h000030, 1'b0, 1'b0);
        do_read(24'h000030, 1'b0, 1'b0);
        do_read(24'h000034, 1'b0, 1'b0);

        prev = 24'h000034;
        for (int i = 0; i < 30; i++) begin
            a     = ($urandom_range(0, 3) == 0) ? prev : 24'($urandom);
            keep  = (i != 29) && ($urandom_range(0, 1) == 1);
            stick = ($urandom_range(0, 7) == 0);
            do_read(a, keep, stick);
            prev = a;
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/flash_word_reader.md
# flash_word_reader

Bus-side front end for the byte-wide SPI flash read controller. Accepts 32-bit word read requests from the CPU/boot bus, sequences four single-byte reads through the controller's `addr`/`rd_trigger`/`busy`/`data_out` handshake, and assembles the bytes little-endian into one word. It sits directly upstream of the SPI flash controller and is the only master of that controller.

## Interface
Parameters:
- `BASE_ADDR`, 24'h000000: flash byte offset added to every bus address.
- `TIMEOUT_CYC`, 4096: maximum clk cycles allowed per byte (ISSUE to capture) before abort; must be ≥ 2.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bus_req`, input, 1: read request, level; held by the master until `bus_ready`.
- `bus_addr`, input, 24: byte address; bits [1:0] are ignored (word aligned).
- `bus_rdata`, output, 32: read word; valid when `bus_ready`=1 and held until the next response.
- `bus_ready`, output, 1: one-cycle completion pulse.
- `bus_err`, output, 1: asserted together with `bus_ready` when the read timed out.
- `flash_addr`, output, 24: byte address to the controller.
- `flash_rd`, output, 1: one-cycle read trigger to the controller.
- `flash_busy`, input, 1: controller busy.
- `flash_data`, input, 8: controller read byte; valid once `flash_busy` falls.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: if `bus_req`=1, latch `wbase = {bus_addr[23:2],2'b00} + BASE_ADDR` (mod 2^24), clear byte index k=0, go to ISSUE. `bus_req` is sampled only in IDLE.
- ISSUE: `flash_addr = wbase + k` (mod 2^24, wraps 24'hFFFFFF→0); `flash_rd`=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for `flash_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `flash_busy`=0, then capture `flash_data` into lane k (byte k → `bus_rdata[8k+7:8k]`). If k=3, go to RESP; otherwise k←k+1 and go to ISSUE.
- Timeout: the counter increments every cycle in WAIT_BUSY/WAIT_DONE. When it reaches `TIMEOUT_CYC`, go to RESP with error: `bus_rdata`←32'hFFFF_FFFF, `bus_err`=1.
- RESP: `bus_ready`=1 for one cycle, then go to IDLE. The master drops `bus_req` in the cycle after it sees `bus_ready`. A `bus_req` that is still high when IDLE is re-entered starts a new read.
- If `bus_req` drops mid-transaction, the transaction still completes and `bus_ready` still pulses.
- `flash_addr` is held stable from ISSUE until the capture in WAIT_DONE.

## Timing
- Reset values: `bus_rdata`=0, `bus_ready`=0, `bus_err`=0, `flash_addr`=0, `flash_rd`=0; state=IDLE, k=0, timeout counter=0.
- A reset asserted mid-read aborts immediately: no `bus_ready` is produced, and the controller is reset by the same `rst_n`.
- Per byte: 1 (ISSUE) + Tb (WAIT_BUSY, ≥1) + Td (WAIT_DONE, ≥1) cycles. With the controller's busy rising one cycle after the trigger, Tb=1.
- Request accepted at edge N: first `flash_rd` is high in cycle N+1. `bus_ready` is high in the cycle after the fourth capture.
- `bus_rdata` changes only on entry to RESP.

## Configuration
- `FLASH_WORD_CACHE_EN` defined:
  - A one-entry cache holds the last successfully read word, its tag `wbase[23:2]`, and a valid bit.
  - In IDLE, a request whose computed `wbase` matches a valid tag goes directly to RESP. `bus_ready` appears 1 cycle after acceptance, with no `flash_rd`.
  - A miss reads from flash and fills the cache at RESP.
  - A timeout clears the valid bit. Reset clears the valid bit.
- `FLASH_WORD_CACHE_EN` undefined:
  - No cache storage exists.
  - Every request performs four flash byte reads.

## Test plan
- Read: model byte(a)=a[7:0]^8'h5A, `BASE_ADDR`=0, `bus_addr`=24'h000103 → `flash_addr` sequence 0x100..0x103, exactly four `flash_rd` pulses, `bus_rdata`=32'h5958_5B5A, `bus_err`=0.
- Wrap: `BASE_ADDR`=24'h000010, `bus_addr`=24'hFFFFF0 → `flash_addr` sequence 0x000000..0x000003, word assembled little-endian.
- Timeout: `TIMEOUT_CYC`=16, `flash_busy` stuck at 0 → `bus_ready`=1 and `bus_err`=1 with `bus_rdata`=32'hFFFF_FFFF; only one `flash_rd` is issued.
- Reset mid-read: assert `rst_n`=0 during byte 2 → all outputs return to reset values, no `bus_ready`. After release, a new read of 0x200 returns the correct word.
- Back-to-back: hold `bus_req` for two consecutive requests (0x000, 0x004) → two `bus_ready` pulses, eight `flash_rd` pulses, each word correct.
- Cache (macro defined): read 0x040 twice → the second read has 0 `flash_rd` pulses, `bus_ready` 1 cycle after acceptance, identical data. Read 0x044 → misses and goes to flash.
